bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//  Parametrised mm:ss BCD countdown timer. Next generation of the level-2 timer.
//  - Preset digits are shifted in serially through data/loadn.
//  - Counts down one second per tick strobe, while enabled.
//  - Adds: N minute digits, a separate 1 Hz tick, digit saturation on load,
//    a one-cycle done pulse, and optional auto-reload of the last preset.
//  - Sits between the keypad/digit-entry logic and the 7-seg display drivers.
// PARAMETERS
//  MIN_DIGITS   1   number of BCD minute digits, legal 1..4 (max 9:59 .. 9999:59)
// PORTS
//  clock        in   1                  single system clock, rising edge
//  clrn         in   1                  reset, asynchronous, active-low
//  data         in   4                  BCD digit to shift in
//  loadn        in   1                  active-low load strobe, one digit per clock
//  enable       in   1                  count permit (pause when 0)
//  tick         in   1                  1-cycle strobe, one per second
//  auto_reload  in   1                  1: reload preset on expiry
//  sec_ones     out  4                  seconds units, 0..9
//  sec_tens     out  4                  seconds tens, 0..5
//  mins         out  4*MIN_DIGITS       minute digits, [3:0] = least significant
//  zero         out  1                  all digits == 0 (decoded from registers)
//  done         out  1                  registered, 1-cycle pulse on expiry
//  running      out  1                  enable & loadn & ~zero (combinational)
// BEHAVIOUR
//  - Reset (clrn=0): immediate, async.
//    - All digits = 0; preset shadow = 0.
//    - Outputs: done=0, zero=1, running=0.
//    - Applies mid-count too; no state survives.
//  - Priority at each rising edge: load > count > hold.
//  - Load (loadn=0): the whole chain shifts left one digit.
//    - sec_ones <= sat9(data), where sat9 maps 4'hA..F to 9.
//    - sec_tens <= min(old sec_ones, 5).
//    - mins[0] <= old sec_tens; mins[k] <= mins[k-1]; top minute digit discarded.
//    - Shadow captures the same new value. Ticks during load are dropped.
//    - done is forced to 0.
//  - Count: happens when loadn=1 & enable=1 & tick=1 & ~zero. Decrement by 1 s.
//    - sec_ones 0 -> 9, with borrow.
//    - sec_tens 0 -> 5, with borrow.
//    - Each minute digit 0 -> 9, with borrow.
//    - Latency: the new value is visible on the outputs one cycle after the tick edge.
//  - Expiry: the counting edge where the value goes from 00:01 to 00:00.
//    - done = 1 for exactly the next cycle.
//    - If auto_reload=1 and shadow != 0: digits <= shadow (zero stays 0; done still pulses).
//    - Otherwise: digits <= 0 and zero = 1.
//  - At zero with no reload: the timer holds. tick/enable are ignored; done is not repeated.
//  - enable=0 or tick=0: hold all digits; done = 0.
//  - Loading a preset of 0 gives zero=1 immediately. No done pulse.
//  - Changing auto_reload mid-count takes effect at the next expiry.
// STRUCTURE
//  - Shared package timer_pkg:
//    - typedef bcd_t (logic [3:0]).
//    - Constants SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_MAX=9.
//    - Function bcd_sat(d, max).
//  - One sub-module: bcd_down_digit #(MAX).
//    - Ports: load, load_val, dec, borrow_in, borrow_out, is_zero, q.
//    - Instantiated 2+MIN_DIGITS times.
//    - Borrow chain is ripple, combinational.
//  - Top level holds the shadow register, load/count/reload muxing, and the done flop.
// TESTING
//  1 Reset: clrn=0 mid-count at 05:37.
//    -> async clear: all digits 0, zero=1, done=0 before the next clock edge.
//  2 Load + count: MIN_DIGITS=1; loadn=0 for 2 cycles with data=1 then 0.
//    -> 0:10. Then enable=1 with 10 ticks -> 0:09 .. 0:00.
//    -> done high exactly 1 cycle; zero=1; extra ticks leave 0:00 and no done.
//  3 Borrow: load 1,0,0.
//    -> 1:00; one tick -> 0:59.
//    -> With MIN_DIGITS=2: load 1,0,0,0 -> 10:00; tick -> 09:59.
//  4 Saturation: load data=4'hC then 4'h7.
//    -> sec_tens=5 (from 9... see rule: 9 clamped to 5), sec_ones=7.
//  5 Auto-reload: preset 0:03, auto_reload=1, 3 ticks -> done pulse and digits 0:03.
//    -> Next 3 ticks -> second done pulse.
//  6 Priority/pause: enable=0 with ticks -> value held.
//    -> tick together with loadn=0 -> load applied, no decrement.
//    -> Preset 0 load -> zero=1, no done.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared BCD timer types, digit limits and the load-time saturation helper.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_ONES_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_MAX      = 4'd9;

  function automatic bcd_t bcd_sat(input bcd_t d, input bcd_t max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD down-counting digit: parallel load, or decrement when the ripple
// borrow reaches it, wrapping 0 -> MAX.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clock,
  input  logic clrn,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec,
  input  logic borrow_in,
  output logic borrow_out,
  output logic is_zero,
  output bcd_t q
);

  bcd_t q_q, q_d;

  assign is_zero    = (q_q == 4'd0);
  assign borrow_out = borrow_in & is_zero;
  assign q          = q_q;

  always_comb begin
    q_d = q_q;
    if (load)                  q_d = load_val;
    else if (dec && borrow_in) q_d = is_zero ? MAX : q_q - 4'd1;
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) q_q <= 4'd0;
    else       q_q <= q_d;
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer with serial preset entry, preset shadow for
// auto-reload, and a one-cycle done pulse on expiry.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 1
) (
  input  logic                    clock,
  input  logic                    clrn,
  input  logic [3:0]              data,
  input  logic                    loadn,
  input  logic                    enable,
  input  logic                    tick,
  input  logic                    auto_reload,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    done,
  output logic                    running
);

  localparam int NDIG = 2 + MIN_DIGITS;

  // digit 0 = seconds ones, 1 = seconds tens, 2.. = minutes (LS first)
  bcd_t [NDIG-1:0] dig, shift_val, load_val, shadow_q, shadow_d;
  logic [NDIG:0]   borrow;
  logic [NDIG-1:0] dzero;
  logic            done_q, done_d;
  logic            count, at_one, expire, reload, dig_load, dec;

  assign borrow[0] = 1'b1;
  assign zero      = &dzero;
  // 00:01 : ones digit is exactly 1 and everything above it is zero
  assign at_one    = ~dzero[0] & (dig[0][3:1] == 3'd0) & (&dzero[NDIG-1:1]);
  assign count     = loadn & enable & tick & ~zero;
  assign expire    = count & at_one;
  assign reload    = expire & auto_reload & (shadow_q != '0);
  assign dig_load  = ~loadn | reload;
  assign dec       = count & ~reload;
  assign load_val  = loadn ? shadow_q : shift_val;
  assign running   = enable & loadn & ~zero;
  assign done      = done_q;

  always_comb begin
    shift_val    = dig;
    shift_val[0] = bcd_sat(data, SEC_ONES_MAX);
    shift_val[1] = bcd_sat(dig[0], SEC_TENS_MAX);
    for (int k = 2; k < NDIG; k++) shift_val[k] = dig[k-1];
  end

  always_comb begin
    shadow_d = shadow_q;
    if (!loadn) shadow_d = shift_val;
  end

  // load clears done implicitly: count requires loadn high
  always_comb begin
    done_d = expire;
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    localparam bcd_t MX = (k == 0) ? SEC_ONES_MAX :
                          (k == 1) ? SEC_TENS_MAX : MIN_MAX;
    bcd_down_digit #(.MAX(MX)) u_dig (
      .clock      (clock),
      .clrn       (clrn),
      .load       (dig_load),
      .load_val   (load_val[k]),
      .dec        (dec),
      .borrow_in  (borrow[k]),
      .borrow_out (borrow[k+1]),
      .is_zero    (dzero[k]),
      .q          (dig[k])
    );
  end

  assign sec_ones = dig[0];
  assign sec_tens = dig[1];
  for (genvar k = 0; k < MIN_DIGITS; k++) begin : g_mins
    assign mins[4*k +: 4] = dig[k+2];
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed scoreboard bench: two timers (1 and 2 minute digits); expected
// mm:ss values are hand-written per stimulus step.
module tb_bcd_countdown_timer;
  import timer_pkg::*;

  logic       clock = 1'b0, clrn = 1'b0;
  logic [3:0] data = 4'd0;
  logic       loadn1 = 1'b1, loadn2 = 1'b1, enable = 1'b0, tick = 1'b0, auto_reload = 1'b0;
  logic [3:0] so1, st1, mins1, so2, st2;
  logic [7:0] mins2;
  logic       zero1, done1, run1, zero2, done2, run2;

  bcd_countdown_timer #(.MIN_DIGITS(1)) u_t1 (
    .clock(clock), .clrn(clrn), .data(data), .loadn(loadn1), .enable(enable),
    .tick(tick), .auto_reload(auto_reload), .sec_ones(so1), .sec_tens(st1),
    .mins(mins1), .zero(zero1), .done(done1), .running(run1));

  bcd_countdown_timer #(.MIN_DIGITS(2)) u_t2 (
    .clock(clock), .clrn(clrn), .data(data), .loadn(loadn2), .enable(enable),
    .tick(tick), .auto_reload(auto_reload), .sec_ones(so2), .sec_tens(st2),
    .mins(mins2), .zero(zero2), .done(done2), .running(run2));

  always #5 clock = ~clock;

  typedef struct {
    bit          sel;
    logic [15:0] val;
    bit          dn;
    bit          z;
    bit          run;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;
  bit   en_cur = 1'b0, ar_cur = 1'b0;
  event sample_now;

  // monitor: compares one queued expectation per negedge (or forced sample)
  initial begin
    exp_t        e;
    logic [18:0] act, req;
    forever begin
      @(negedge clock or sample_now);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = e.sel ? {mins2, st2, so2, zero2, done2, run2}
                    : {4'h0, mins1, st1, so1, zero1, done1, run1};
        req = {e.val, e.z, e.dn, e.run};
        n_vec++;
        if (act !== req) begin
          n_err++;
          $display("FAIL %s dut%0d: got mmss=%h z/d/r=%b required mmss=%h z/d/r=%b",
                   e.nm, e.sel + 1, act[18:3], act[2:0], req[18:3], req[2:0]);
        end
      end
    end
  end

  task automatic expect_now(input bit sel, input logic [15:0] v, input bit dn, input string nm);
    exp_t e;
    e.sel = sel; e.val = v; e.dn = dn; e.z = (v == 16'h0);
    e.run = en_cur && (v != 16'h0); e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input bit sel, input bit ld, input logic [3:0] d, input bit tk,
                      input logic [15:0] v, input bit dn, input string nm);
    @(negedge clock); #1;
    data = d; tick = tk; enable = en_cur; auto_reload = ar_cur;
    if (sel) loadn2 = ~ld; else loadn1 = ~ld;
    @(posedge clock); #1;
    loadn1 = 1'b1; loadn2 = 1'b1; tick = 1'b0;
    expect_now(sel, v, dn, nm);
  endtask

  task automatic ld(input bit sel, input logic [3:0] d, input logic [15:0] v);
    step(sel, 1'b1, d, 1'b0, v, 1'b0, "load");
  endtask

  task automatic tk(input logic [15:0] v, input bit dn);
    step(1'b0, 1'b0, 4'd0, 1'b1, v, dn, "tick");
  endtask

  initial begin
    // reset state of both timers, sampled while clrn is still low
    #2; expect_now(1'b0, 16'h0000, 1'b0, "reset_state"); ->sample_now;
    #1; expect_now(1'b1, 16'h0000, 1'b0, "reset_state"); ->sample_now;
    #8; clrn = 1'b1;

    // async clear mid-count at 05:37
    ld(0, 4'd5, 16'h0005); ld(0, 4'd3, 16'h0053); ld(0, 4'd7, 16'h0537);
    en_cur = 1'b1; tk(16'h0536, 1'b0);
    @(negedge clock); #1;
    clrn = 1'b0;
    expect_now(1'b0, 16'h0000, 1'b0, "async_clear");
    #1 ->sample_now;
    @(negedge clock); #1 clrn = 1'b1;

    // load 0:10 and count down to expiry
    en_cur = 1'b0;
    ld(0, 4'd1, 16'h0001); ld(0, 4'd0, 16'h0010);
    en_cur = 1'b1;
    for (int v = 9; v >= 1; v--) tk(16'(v), 1'b0);
    tk(16'h0000, 1'b1);
    step(0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, "done_once");
    tk(16'h0000, 1'b0); tk(16'h0000, 1'b0);

    // borrow across minutes
    ld(0, 4'd1, 16'h0001); ld(0, 4'd0, 16'h0010); ld(0, 4'd0, 16'h0100);
    tk(16'h0059, 1'b0);

    // saturation: C -> 9 on ones, then 9 -> 5 on tens
    ld(0, 4'hC, 16'h0559); ld(0, 4'd7, 16'h0557);

    // zero preset gives zero without done, then auto-reload of 0:03
    ld(0, 4'd0, 16'h0550); ld(0, 4'd0, 16'h0500); ld(0, 4'd0, 16'h0000);
    ld(0, 4'd3, 16'h0003);
    ar_cur = 1'b1;
    tk(16'h0002, 1'b0); tk(16'h0001, 1'b0); tk(16'h0003, 1'b1);
    step(0, 1'b0, 4'd0, 1'b0, 16'h0003, 1'b0, "reload_hold");
    tk(16'h0002, 1'b0); tk(16'h0001, 1'b0); tk(16'h0003, 1'b1);
    ar_cur = 1'b0;
    tk(16'h0002, 1'b0); tk(16'h0001, 1'b0); tk(16'h0000, 1'b1); tk(16'h0000, 1'b0);

    // pause, load-over-tick priority, zero preset
    ld(0, 4'd4, 16'h0004);
    en_cur = 1'b0; tk(16'h0004, 1'b0); tk(16'h0004, 1'b0);
    en_cur = 1'b1;
    step(0, 1'b1, 4'd2, 1'b1, 16'h0042, 1'b0, "load_over_tick");
    tk(16'h0041, 1'b0);
    ld(0, 4'd0, 16'h0410); ld(0, 4'd0, 16'h0100); ld(0, 4'd0, 16'h0000);
    tk(16'h0000, 1'b0);

    // two minute digits: 10:00 -> 09:59
    ld(1, 4'd1, 16'h0001); ld(1, 4'd0, 16'h0010); ld(1, 4'd0, 16'h0100); ld(1, 4'd0, 16'h1000);
    step(1, 1'b0, 4'd0, 1'b1, 16'h0959, 1'b0, "tick_2min");

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clock); #1;
    end
    if (sb.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d expectations never compared, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
